// File: rtl/icache_tag_assoc.sv
// N-way set-associative instruction-cache tag store.
// Combinational lookup and victim selection; registered fills, true-LRU
// age updates and a one-set-per-cycle invalidation sweep for fence.i.
module icache_tag_assoc #(
  parameter int TAG_LEN = 23,
  parameter int IDX_LEN = 5,
  parameter int WAYS    = 2,
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TAG_LEN-1:0] icache_tag_i,
  input  logic [IDX_LEN-1:0] icache_index_i,
  input  logic               lookup_valid_i,
  input  logic               fill_valid_i,
  input  logic               flush_i,
  output logic               icache_hit_o,
  output logic [WAY_W-1:0]   hit_way_o,
  output logic [WAY_W-1:0]   victim_way_o,
  output logic               flush_busy_o
);

  localparam int SETS = 1 << IDX_LEN;
  localparam logic [WAY_W-1:0] OLDEST_AGE = WAY_W'(WAYS - 1);

  // Per-set state. Ages within a set always form a permutation of
  // 0..WAYS-1 with 0 meaning most recently used.
  logic [WAYS-1:0]    valid_r [SETS];
  logic [TAG_LEN-1:0] tag_r   [SETS][WAYS];
  logic [WAY_W-1:0]   age_r   [SETS][WAYS];
  logic [IDX_LEN-1:0] flush_ptr_r;
  logic               flush_busy_r;

  logic               hit_any_s;
  logic [WAY_W-1:0]   hit_way_s;
  logic               any_invalid_s;
  logic [WAY_W-1:0]   invalid_way_s;
  logic [WAY_W-1:0]   oldest_way_s;
  logic [WAY_W-1:0]   victim_s;
  logic [WAY_W-1:0]   touch_way_s;
  logic [WAY_W-1:0]   touch_ref_age_s;
  logic [WAY_W-1:0]   touch_age_s [WAYS];

  // Tag compare across the indexed set; scanning downward leaves the lowest matching way.
  always_comb begin
    hit_any_s = 1'b0;
    hit_way_s = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_r[icache_index_i][w] && (tag_r[icache_index_i][w] == icache_tag_i)) begin
        hit_any_s = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
  end

  // Victim choice: lowest invalid way first, otherwise the least recently used way.
  always_comb begin
    any_invalid_s = 1'b0;
    invalid_way_s = '0;
    oldest_way_s  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_r[icache_index_i][w]) begin
        any_invalid_s = 1'b1;
        invalid_way_s = WAY_W'(w);
      end else begin
        invalid_way_s = invalid_way_s;
      end
      if (age_r[icache_index_i][w] == OLDEST_AGE) begin
        oldest_way_s = WAY_W'(w);
      end else begin
        oldest_way_s = oldest_way_s;
      end
    end
    if (any_invalid_s) begin
      victim_s = invalid_way_s;
    end else begin
      victim_s = oldest_way_s;
    end
  end

  // LRU touch: a fill that misses touches the victim, everything else touches the hit way.
  always_comb begin
    if (fill_valid_i && !hit_any_s) begin
      touch_way_s = victim_s;
    end else begin
      touch_way_s = hit_way_s;
    end
    touch_ref_age_s = age_r[icache_index_i][touch_way_s];
    for (int w = 0; w < WAYS; w++) begin
      touch_age_s[w] = age_r[icache_index_i][w];
      if (WAY_W'(w) == touch_way_s) begin
        touch_age_s[w] = '0;
      end else if (age_r[icache_index_i][w] < touch_ref_age_s) begin
        touch_age_s[w] = age_r[icache_index_i][w] + WAY_W'(1);
      end else begin
        touch_age_s[w] = age_r[icache_index_i][w];
      end
    end
  end

  // Output drive; hits are suppressed while the sweep is running.
  always_comb begin
    icache_hit_o = hit_any_s && !flush_busy_r;
    if (icache_hit_o) begin
      hit_way_o = hit_way_s;
    end else begin
      hit_way_o = '0;
    end
    victim_way_o = victim_s;
    flush_busy_o = flush_busy_r;
  end

  // State update in priority order: reset, sweep step, flush start, fill, lookup hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_busy_r <= 1'b0;
      flush_ptr_r  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_r[s][w] <= WAY_W'(w);
        end
      end
    end else if (flush_busy_r) begin
      valid_r[flush_ptr_r] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        age_r[flush_ptr_r][w] <= WAY_W'(w);
      end
      if (flush_ptr_r == {IDX_LEN{1'b1}}) begin
        flush_busy_r <= 1'b0;
      end else begin
        flush_ptr_r <= flush_ptr_r + IDX_LEN'(1);
      end
    end else if (flush_i) begin
      flush_busy_r <= 1'b1;
      flush_ptr_r  <= '0;
    end else if (fill_valid_i) begin
      // A fill that already hits only refreshes recency, so no duplicate line appears.
      if (!hit_any_s) begin
        tag_r[icache_index_i][victim_s]   <= icache_tag_i;
        valid_r[icache_index_i][victim_s] <= 1'b1;
      end
      for (int w = 0; w < WAYS; w++) begin
        age_r[icache_index_i][w] <= touch_age_s[w];
      end
    end else if (lookup_valid_i && hit_any_s) begin
      for (int w = 0; w < WAYS; w++) begin
        age_r[icache_index_i][w] <= touch_age_s[w];
      end
    end
  end

endmodule

// File: tb/tb_icache_tag_assoc.sv
// Scoreboard bench: a 2-way and a 4-way instance share one stimulus stream;
// the driver queues hand-computed expectations, a negedge monitor compares.
module tb_icache_tag_assoc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] tag_s = '0;
  logic [4:0]  idx_s = '0;
  logic        lk_s = 1'b0;
  logic        fill_s = 1'b0;
  logic        flush_s = 1'b0;
  logic        chk_req = 1'b0;

  logic       h2, b2, h4, b4;
  logic [0:0] hw2, v2;
  logic [1:0] hw4, v4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    kind;   // 0: port outputs, 1: age vector of a set in the 4-way instance
    int    dut;    // 0: 2-way, 1: 4-way
    int    hit;
    int    way;
    int    vic;
    int    busy;
    int    set;
    int    ages;
    string name;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  icache_tag_assoc #(.TAG_LEN(23), .IDX_LEN(5), .WAYS(2)) dut2 (
    .clk(clk), .rst(rst), .icache_tag_i(tag_s), .icache_index_i(idx_s),
    .lookup_valid_i(lk_s), .fill_valid_i(fill_s), .flush_i(flush_s),
    .icache_hit_o(h2), .hit_way_o(hw2), .victim_way_o(v2), .flush_busy_o(b2));

  icache_tag_assoc #(.TAG_LEN(23), .IDX_LEN(5), .WAYS(4)) dut4 (
    .clk(clk), .rst(rst), .icache_tag_i(tag_s), .icache_index_i(idx_s),
    .lookup_valid_i(lk_s), .fill_valid_i(fill_s), .flush_i(flush_s),
    .icache_hit_o(h4), .hit_way_o(hw4), .victim_way_o(v4), .flush_busy_o(b4));

  function automatic int pk(input int a0, input int a1, input int a2, input int a3);
    return a0 | (a1 << 2) | (a2 << 4) | (a3 << 6);
  endfunction

  // Monitor: pops one expectation per requested sample, away from the rising edge.
  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: sample requested with no expectation queued");
      end else begin
        exp_t e;
        int ah, aw, av, ab, aa;
        e = sb_q.pop_front();
        if (e.kind == 0) begin
          if (e.dut == 0) begin
            ah = int'(h2); aw = int'(hw2); av = int'(v2); ab = int'(b2);
          end else begin
            ah = int'(h4); aw = int'(hw4); av = int'(v4); ab = int'(b4);
          end
          if (ah != e.hit || aw != e.way || av != e.vic || ab != e.busy) begin
            errors++;
            $display("FAIL %s: got hit=%0d way=%0d victim=%0d busy=%0d, want hit=%0d way=%0d victim=%0d busy=%0d",
                     e.name, ah, aw, av, ab, e.hit, e.way, e.vic, e.busy);
          end
        end else begin
          aa = 0;
          for (int w = 0; w < 4; w++) begin
            aa = aa | (int'(dut4.age_r[e.set][w]) << (2 * w));
          end
          if (aa != e.ages) begin
            errors++;
            $display("FAIL %s: got ages=0x%02h want ages=0x%02h", e.name, aa, e.ages);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int d, input int ix, input int tg, input logic lk, input logic fs,
                       input int eh, input int ew, input int ev, input int eb, input string nm);
    exp_t e;
    idx_s = ix[4:0]; tag_s = tg[22:0]; lk_s = lk; fill_s = fs;
    e.kind = 0; e.dut = d; e.hit = eh; e.way = ew; e.vic = ev; e.busy = eb;
    e.set = 0; e.ages = 0; e.name = nm;
    sb_q.push_back(e);
    chk_req = 1'b1;
    step();
    chk_req = 1'b0; lk_s = 1'b0; fill_s = 1'b0;
  endtask

  task automatic agechk(input int s, input int ages, input string nm);
    exp_t e;
    e.kind = 1; e.dut = 1; e.hit = 0; e.way = 0; e.vic = 0; e.busy = 0;
    e.set = s; e.ages = ages; e.name = nm;
    sb_q.push_back(e);
    chk_req = 1'b1;
    step();
    chk_req = 1'b0;
  endtask

  task automatic fill(input int ix, input int tg);
    idx_s = ix[4:0]; tag_s = tg[22:0]; fill_s = 1'b1;
    step();
    fill_s = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_s = 1'b1;
    step();
    flush_s = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    probe(0, 3, 'h12345, 1'b1, 1'b0, 0, 0, 0, 0, "reset_w2");
    probe(1, 3, 'h12345, 1'b1, 1'b0, 0, 0, 0, 0, "reset_w4");
    agechk(3, pk(0, 1, 2, 3), "reset_ages_set3");

    // 2-way replacement at index 3
    fill(3, 'hAAA);
    fill(3, 'hBBB);
    probe(0, 3, 'hAAA, 1'b1, 1'b0, 1, 0, 0, 0, "w2_lookup_A");
    probe(0, 3, 'hAAA, 1'b0, 1'b0, 1, 0, 1, 0, "w2_victim_after_A");
    fill(3, 'hCCC);
    probe(0, 3, 'hBBB, 1'b0, 1'b0, 0, 0, 0, 0, "w2_B_evicted");
    probe(0, 3, 'hAAA, 1'b1, 1'b0, 1, 0, 0, 0, "w2_A_kept");
    probe(0, 3, 'hCCC, 1'b0, 1'b0, 1, 1, 1, 0, "w2_C_way1");

    // 4-way LRU order at index 7
    for (int t = 0; t < 4; t++) fill(7, 'h70 + t);
    probe(1, 7, 'h70, 1'b0, 1'b0, 1, 0, 0, 0, "w4_full_victim");
    probe(1, 7, 'h70, 1'b1, 1'b0, 1, 0, 0, 0, "w4_lookup_T0");
    probe(1, 7, 'h72, 1'b1, 1'b0, 1, 2, 1, 0, "w4_lookup_T2");
    probe(1, 7, 'h71, 1'b1, 1'b0, 1, 1, 1, 0, "w4_lookup_T1");
    probe(1, 7, 'h73, 1'b1, 1'b0, 1, 3, 3, 0, "w4_lookup_T3");
    probe(1, 7, 'h73, 1'b0, 1'b0, 1, 3, 0, 0, "w4_victim_after_T3");
    agechk(7, pk(3, 1, 2, 0), "w4_ages_set7");

    // Fill of a tag that already hits at index 5
    for (int t = 0; t < 3; t++) fill(5, 'h50 + t);
    probe(1, 5, 'h50, 1'b0, 1'b0, 1, 0, 3, 0, "w4_pre_refill");
    fill(5, 'h50);
    probe(1, 5, 'h50, 1'b0, 1'b0, 1, 0, 3, 0, "w4_refill_same_way");
    probe(1, 5, 'h51, 1'b0, 1'b0, 1, 1, 3, 0, "w4_refill_other_way");
    agechk(5, pk(0, 2, 1, 3), "w4_refill_ages");
    fill(5, 'h53);
    probe(1, 5, 'h53, 1'b0, 1'b0, 1, 3, 1, 0, "w4_refill_lru_effect");

    // Flush sweep
    fill(0, 'h100);
    fill(15, 'h115);
    fill(31, 'h131);
    probe(0, 31, 'h131, 1'b0, 1'b0, 1, 0, 1, 0, "w2_pre_flush");
    pulse_flush();
    for (int i = 0; i < 32; i++) begin
      if (i == 20) probe(0, 0, 'h555, 1'b0, 1'b1, 0, 0, 0, 1, "sweep_fill_cycle");
      else         probe(0, 31, 'h131, 1'b1, 1'b0, 0, 0, 1, 1, "sweep_busy");
    end
    probe(0, 31, 'h131, 1'b0, 1'b0, 0, 0, 0, 0, "post_sweep_idx31");
    probe(0, 15, 'h115, 1'b0, 1'b0, 0, 0, 0, 0, "post_sweep_idx15");
    probe(0, 0, 'h100, 1'b0, 1'b0, 0, 0, 0, 0, "post_sweep_idx0");
    probe(0, 0, 'h555, 1'b0, 1'b0, 0, 0, 0, 0, "sweep_fill_dropped");
    probe(1, 7, 'h73, 1'b0, 1'b0, 0, 0, 0, 0, "post_sweep_w4_idx7");
    probe(1, 5, 'h50, 1'b0, 1'b0, 0, 0, 0, 0, "post_sweep_w4_idx5");

    // Reset in the middle of a sweep
    fill(20, 'hA0);
    fill(20, 'hB0);
    agechk(20, pk(1, 0, 2, 3), "w4_ages_set20_pre");
    pulse_flush();
    for (int i = 0; i < 10; i++) probe(1, 20, 'hA0, 1'b0, 1'b0, 0, 0, 2, 1, "sweep2_busy");
    rst = 1'b1;
    step();
    rst = 1'b0;
    probe(1, 20, 'hA0, 1'b0, 1'b0, 0, 0, 0, 0, "midsweep_reset_w4");
    probe(0, 20, 'hB0, 1'b0, 1'b0, 0, 0, 0, 0, "midsweep_reset_w2");
    agechk(20, pk(0, 1, 2, 3), "midsweep_ages_set20");
    agechk(31, pk(0, 1, 2, 3), "midsweep_ages_set31");
    agechk(7, pk(0, 1, 2, 3), "midsweep_ages_set7");

    step();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expectations, want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
